// File: rtl/framebuffer_readback.sv
`timescale 1ns/1ps
// framebuffer_readback
// Samples one pixel of the live VGA RGB stream at a requested (x, y) and returns it to software
// over a toggle handshake. The block only observes the stream and never stalls it.
//
// Ports:
//   CLK, RESET_N            VGA pixel clock; asynchronous active-low reset
//   REQ_TOGGLE              request strobe (async to CLK); any level change is one request
//   REQ_X, REQ_Y [9:0]      requested column / row, held stable until ACK_TOGGLE changes
//   VGA_DE, VGA_VS          active-video qualifier; vertical sync (active low)
//   R_IN, G_IN, B_IN [7:0]  pixel stream aligned to VGA_DE
//   RD_DATA [23:0]          {R,G,B} of the captured pixel (0 on error)
//   RD_ERR                  last request failed (out of range or timeout)
//   ACK_TOGGLE              toggles once per completed request
//   BUSY                    request in progress
module framebuffer_readback #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned TIMEOUT_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_TOGGLE,
    input  logic [9:0]  REQ_X,
    input  logic [9:0]  REQ_Y,
    input  logic        VGA_DE,
    input  logic        VGA_VS,
    input  logic [7:0]  R_IN,
    input  logic [7:0]  G_IN,
    input  logic [7:0]  B_IN,
    output logic [23:0] RD_DATA,
    output logic        RD_ERR,
    output logic        ACK_TOGGLE,
    output logic        BUSY
);

    typedef enum logic [1:0] {StIdle, StCheck, StSeek} state_e;

    localparam logic [9:0] CntMax = 10'd1023;

    // Reset: asserts asynchronously, releases synchronously to CLK.
    logic rst_meta_q, rst_sync_n;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_n <= rst_meta_q;
        end
    end

    // Request synchroniser and position tracking.
    logic       req_meta_q, req_sync_q;
    logic       de_q, vs_q;
    logic [9:0] x_cnt_q, y_cnt_q;
    logic       de_fall, vs_fall;

    assign de_fall = de_q & ~VGA_DE;
    assign vs_fall = vs_q & ~VGA_VS;

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            req_meta_q <= 1'b0;
            req_sync_q <= 1'b0;
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
        end else begin
            req_meta_q <= REQ_TOGGLE;
            req_sync_q <= req_meta_q;
            de_q       <= VGA_DE;
            vs_q       <= VGA_VS;
            if (VGA_DE) begin
                if (x_cnt_q != CntMax) x_cnt_q <= x_cnt_q + 10'd1;
            end else if (de_fall) begin
                x_cnt_q <= '0;
            end
            // Frame start wins over a line end in the same cycle.
            if (vs_fall) begin
                y_cnt_q <= '0;
            end else if (de_fall && (y_cnt_q != CntMax)) begin
                y_cnt_q <= y_cnt_q + 10'd1;
            end
        end
    end

    // Request FSM.
    state_e      state_q, state_d;
    logic        req_seen_q, req_seen_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [23:0] data_q, data_d;
    logic        err_q, err_d, ack_q, ack_d, busy_q, busy_d;
    logic        pending, out_of_range, match, timeout;

    assign pending      = req_sync_q != req_seen_q;
    assign out_of_range = ({1'b0, x_q} >= 11'(H_ACTIVE)) || ({1'b0, y_q} >= 11'(V_ACTIVE));
    // Counter values are the position of the pixel on the current DE cycle.
    assign match        = VGA_DE && (x_cnt_q == x_q) && (y_cnt_q == y_q);
    assign timeout      = frame_cnt_q == 8'(TIMEOUT_FRAMES);

    always_comb begin
        state_d     = state_q;
        req_seen_d  = req_seen_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        data_d      = data_q;
        err_d       = err_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (pending) begin
                    x_d        = REQ_X;
                    y_d        = REQ_Y;
                    req_seen_d = req_sync_q;
                    busy_d     = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (out_of_range) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    frame_cnt_d = '0;
                    state_d     = StSeek;
                end
            end
            StSeek: begin
                // A match in the same cycle as the timeout still returns the pixel.
                if (match) begin
                    data_d  = {R_IN, G_IN, B_IN};
                    err_d   = 1'b0;
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    ack_d   = ~ack_q;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (vs_fall) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= StIdle;
            req_seen_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_seen_q  <= req_seen_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign RD_DATA    = data_q;
    assign RD_ERR     = err_q;
    assign ACK_TOGGLE = ack_q;
    assign BUSY       = busy_q;

endmodule
